id_pipe_ctrl: RTL and testbench

ID_PIPE_CTRL -- requirements
Module: id_pipe_ctrl

---
 rtl/id_pipe_ctrl_pkg.sv | 16 +
 rtl/id_pipe_ctrl_if.sv | 43 ++++
 rtl/id_pipe_ctrl_fwd_sel.sv | 29 ++
 rtl/id_pipe_ctrl.sv | 108 ++++++++++
 tb/tb_id_pipe_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/id_pipe_ctrl_pkg.sv
// Shared constants for the ID-stage pipeline controller: forward-select
// encodings and register-field positions within the instruction word.
package id_pipe_ctrl_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned RS_LSB = 21;
   localparam int unsigned RT_LSB = 16;

   typedef enum logic [1:0] {
      FWD_RF      = 2'b00,
      FWD_EX      = 2'b01,
      FWD_MEM_ALU = 2'b10,
      FWD_MEM_LD  = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/id_pipe_ctrl_if.sv
// IF/EX/MEM-facing bus of the ID pipeline controller; the pipeline drives
// through the master modport, the controller sits on the slave modport.
interface id_pipe_ctrl_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned CNT_W  = 16
);
   logic              if_valid;
   logic [DATA_W-1:0] if_inst;
   logic [DATA_W-1:0] if_pc4;
   logic [TAG_W-1:0]  if_tag;
   logic              flush;
   logic              ex_wreg;
   logic              ex_m2reg;
   logic [4:0]        ex_destR;
   logic              mem_wreg;
   logic              mem_m2reg;
   logic [4:0]        mem_destR;

   logic              id_valid;
   logic              id_issue;
   logic [DATA_W-1:0] id_inst;
   logic [DATA_W-1:0] id_pc4;
   logic [TAG_W-1:0]  id_tag;
   logic              stall;
   logic [1:0]        fwda;
   logic [1:0]        fwdb;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output if_valid, if_inst, if_pc4, if_tag, flush,
             ex_wreg, ex_m2reg, ex_destR, mem_wreg, mem_m2reg, mem_destR,
      input  id_valid, id_issue, id_inst, id_pc4, id_tag, stall,
             fwda, fwdb, stall_cnt
   );

   modport slave (
      input  if_valid, if_inst, if_pc4, if_tag, flush,
             ex_wreg, ex_m2reg, ex_destR, mem_wreg, mem_m2reg, mem_destR,
      output id_valid, id_issue, id_inst, id_pc4, id_tag, stall,
             fwda, fwdb, stall_cnt
   );
endinterface

// File: rtl/id_pipe_ctrl_fwd_sel.sv
// Operand-source select for one ID-stage source register; the youngest
// producer (EX ALU result) wins over MEM, and $0 never forwards.
module id_fwd_sel
   import id_pipe_ctrl_pkg::*;
(
   input  logic             valid,
   input  logic [REG_W-1:0] src,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic [REG_W-1:0] mem_dest,
   output fwd_sel_e         sel_c
);

   // A load still in EX cannot forward; the stall covers it and MEM is consulted instead
   always_comb begin
      sel_c = FWD_RF;
      if (valid && (src != '0)) begin
         if (ex_wreg && !ex_m2reg && (ex_dest == src)) begin
            sel_c = FWD_EX;
         end else if (mem_wreg && (mem_dest == src)) begin
            sel_c = mem_m2reg ? FWD_MEM_LD : FWD_MEM_ALU;
         end
      end
   end

endmodule

// File: rtl/id_pipe_ctrl.sv
// ID-stage latch with load-use stall detection, flush handling, operand
// forward selection and a saturating stall-cycle counter.
module id_pipe_ctrl
   import id_pipe_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic          clk,
   input  logic          rst,
   id_pipe_ctrl_if.slave bus
);

   logic              id_valid_q,  id_valid_d;
   logic [DATA_W-1:0] id_inst_q,   id_inst_d;
   logic [DATA_W-1:0] id_pc4_q,    id_pc4_d;
   logic [TAG_W-1:0]  id_tag_q,    id_tag_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic [REG_W-1:0]  rs_c;
   logic [REG_W-1:0]  rt_c;
   logic              ex_hit_c;
   logic              stall_c;
   logic              issue_c;
   fwd_sel_e          fwda_c;
   fwd_sel_e          fwdb_c;

   assign rs_c     = id_inst_q[RS_LSB +: REG_W];
   assign rt_c     = id_inst_q[RT_LSB +: REG_W];
   assign ex_hit_c = (bus.ex_destR != '0) &&
                     ((bus.ex_destR == rs_c) || (bus.ex_destR == rt_c));
   assign stall_c  = id_valid_q && bus.ex_wreg && bus.ex_m2reg && ex_hit_c;
   assign issue_c  = id_valid_q && !stall_c;

   // Flush beats stall; pc4 is kept on flush so only the payload is killed
   always_comb begin
      id_valid_d  = id_valid_q;
      id_inst_d   = id_inst_q;
      id_pc4_d    = id_pc4_q;
      id_tag_d    = id_tag_q;
      stall_cnt_d = stall_cnt_q;
      if (bus.flush) begin
         id_valid_d = 1'b0;
         id_inst_d  = '0;
         id_tag_d   = '0;
      end else if (!stall_c) begin
         id_valid_d = bus.if_valid;
         id_inst_d  = bus.if_inst;
         id_pc4_d   = bus.if_pc4;
         id_tag_d   = bus.if_tag;
      end
      if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid_q  <= 1'b0;
         id_inst_q   <= '0;
         id_pc4_q    <= '0;
         id_tag_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         id_valid_q  <= id_valid_d;
         id_inst_q   <= id_inst_d;
         id_pc4_q    <= id_pc4_d;
         id_tag_q    <= id_tag_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   id_fwd_sel u_fwd_rs (
      .valid     (id_valid_q),
      .src       (rs_c),
      .ex_wreg   (bus.ex_wreg),
      .ex_m2reg  (bus.ex_m2reg),
      .ex_dest   (bus.ex_destR),
      .mem_wreg  (bus.mem_wreg),
      .mem_m2reg (bus.mem_m2reg),
      .mem_dest  (bus.mem_destR),
      .sel_c     (fwda_c)
   );

   id_fwd_sel u_fwd_rt (
      .valid     (id_valid_q),
      .src       (rt_c),
      .ex_wreg   (bus.ex_wreg),
      .ex_m2reg  (bus.ex_m2reg),
      .ex_dest   (bus.ex_destR),
      .mem_wreg  (bus.mem_wreg),
      .mem_m2reg (bus.mem_m2reg),
      .mem_dest  (bus.mem_destR),
      .sel_c     (fwdb_c)
   );

   assign bus.id_valid  = id_valid_q;
   assign bus.id_issue  = issue_c;
   assign bus.id_inst   = id_inst_q;
   assign bus.id_pc4    = id_pc4_q;
   assign bus.id_tag    = issue_c ? id_tag_q : '0;
   assign bus.stall     = stall_c;
   assign bus.fwda      = fwda_c;
   assign bus.fwdb      = fwdb_c;
   assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_pipe_ctrl.sv
// Directed scoreboard bench for id_pipe_ctrl: stimulus pushes expected
// outputs per cycle, a monitor pops and compares between clock edges.
module tb_id_pipe_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned CNT_W  = 4;

   localparam logic [31:0] I_LW   = 32'h8C22_0004; // lw  $2,4($1)   rs=1 rt=2
   localparam logic [31:0] I_A24  = 32'h0044_1820; // add $3,$2,$4   rs=2 rt=4
   localparam logic [31:0] I_A56  = 32'h00A6_3820; // add $7,$5,$6   rs=5 rt=6
   localparam logic [31:0] I_A05  = 32'h0005_1820; // add $3,$0,$5   rs=0 rt=5
   localparam logic [31:0] I_A22  = 32'h0042_1820; // add $3,$2,$2   rs=2 rt=2

   typedef struct packed {
      logic              valid;
      logic              issue;
      logic [DATA_W-1:0] inst;
      logic [DATA_W-1:0] pc4;
      logic [TAG_W-1:0]  tag;
      logic              stall;
      logic [1:0]        fwda;
      logic [1:0]        fwdb;
      logic [CNT_W-1:0]  cnt;
   } exp_t;

   logic clk;
   logic rst;
   exp_t  exp_q[$];
   string name_q[$];
   int    errors;
   int    checks;

   id_pipe_ctrl_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   id_pipe_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drv(input logic v, input logic [31:0] inst, input logic [31:0] pc4,
                      input logic [7:0] tag, input logic fl,
                      input logic exw, input logic exm, input logic [4:0] exd,
                      input logic mw, input logic mm, input logic [4:0] md);
      bus.if_valid  = v;
      bus.if_inst   = inst;
      bus.if_pc4    = pc4;
      bus.if_tag    = tag;
      bus.flush     = fl;
      bus.ex_wreg   = exw;
      bus.ex_m2reg  = exm;
      bus.ex_destR  = exd;
      bus.mem_wreg  = mw;
      bus.mem_m2reg = mm;
      bus.mem_destR = md;
   endtask

   task automatic expect_out(input string name, input logic v, input logic [31:0] inst,
                             input logic [31:0] pc4, input logic [7:0] tag,
                             input logic st, input logic [1:0] fa, input logic [1:0] fb,
                             input logic [3:0] cnt);
      exp_t e;
      e.valid = v;
      e.issue = v & ~st;
      e.inst  = inst;
      e.pc4   = pc4;
      e.tag   = tag;
      e.stall = st;
      e.fwda  = fa;
      e.fwdb  = fb;
      e.cnt   = cnt;
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Monitor: compares every queued expectation 2 time units after the falling edge
   initial begin
      exp_t  e;
      exp_t  a;
      string n;
      forever begin
         @(negedge clk);
         #2;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.valid = bus.id_valid;
            a.issue = bus.id_issue;
            a.inst  = bus.id_inst;
            a.pc4   = bus.id_pc4;
            a.tag   = bus.id_tag;
            a.stall = bus.stall;
            a.fwda  = bus.fwda;
            a.fwdb  = bus.fwdb;
            a.cnt   = bus.stall_cnt;
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s: got v=%b iss=%b inst=%h pc4=%h tag=%h st=%b fa=%b fb=%b cnt=%0d ; want v=%b iss=%b inst=%h pc4=%h tag=%h st=%b fa=%b fb=%b cnt=%0d",
                        n, a.valid, a.issue, a.inst, a.pc4, a.tag, a.stall, a.fwda, a.fwdb, a.cnt,
                        e.valid, e.issue, e.inst, e.pc4, e.tag, e.stall, e.fwda, e.fwdb, e.cnt);
            end
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      drv(1, I_LW, 32'h4, 8'h11, 0, 0, 0, 5'd0, 0, 0, 5'd0);

      @(negedge clk);
      expect_out("reset_state", 0, 32'h0, 32'h0, 8'h00, 0, 2'b00, 2'b00, 4'd0);

      @(negedge clk);
      rst = 1'b0;
      expect_out("reset_release_idle", 0, 32'h0, 32'h0, 8'h00, 0, 2'b00, 2'b00, 4'd0);

      @(negedge clk);
      drv(1, I_A24, 32'h8, 8'h12, 0, 0, 0, 5'd0, 0, 0, 5'd0);
      expect_out("first_load", 1, I_LW, 32'h4, 8'h11, 0, 2'b00, 2'b00, 4'd0);

      @(negedge clk);
      drv(1, I_A56, 32'hC, 8'h13, 0, 1, 1, 5'd2, 0, 0, 5'd0);
      expect_out("loaduse_stall", 1, I_A24, 32'h8, 8'h00, 1, 2'b00, 2'b00, 4'd0);

      @(negedge clk);
      drv(1, I_A56, 32'hC, 8'h13, 0, 0, 0, 5'd0, 1, 1, 5'd2);
      expect_out("loaduse_mem_ld", 1, I_A24, 32'h8, 8'h12, 0, 2'b11, 2'b00, 4'd1);

      @(negedge clk);
      drv(1, I_A05, 32'h10, 8'h14, 0, 1, 0, 5'd5, 1, 0, 5'd5);
      expect_out("alu_fwd_ex_wins", 1, I_A56, 32'hC, 8'h13, 0, 2'b01, 2'b00, 4'd1);

      @(negedge clk);
      drv(1, I_A22, 32'h14, 8'h15, 0, 1, 0, 5'd0, 1, 0, 5'd5);
      expect_out("zero_reg_mem_alu", 1, I_A05, 32'h10, 8'h14, 0, 2'b00, 2'b10, 4'd1);

      @(negedge clk);
      drv(1, I_A56, 32'h18, 8'h16, 0, 1, 1, 5'd2, 0, 0, 5'd0);
      expect_out("dual_match_stall", 1, I_A22, 32'h14, 8'h00, 1, 2'b00, 2'b00, 4'd1);

      @(negedge clk);
      drv(1, I_A56, 32'h18, 8'h16, 0, 0, 0, 5'd0, 1, 1, 5'd2);
      expect_out("dual_match_fwd", 1, I_A22, 32'h14, 8'h15, 0, 2'b11, 2'b11, 4'd2);

      @(negedge clk);
      drv(1, I_A24, 32'h1C, 8'h17, 1, 1, 1, 5'd5, 0, 0, 5'd0);
      expect_out("flush_stall_pre", 1, I_A56, 32'h18, 8'h00, 1, 2'b00, 2'b00, 4'd2);

      @(negedge clk);
      drv(1, I_LW, 32'h20, 8'h18, 0, 0, 0, 5'd0, 0, 0, 5'd0);
      expect_out("flush_stall_post", 0, 32'h0, 32'h18, 8'h00, 0, 2'b00, 2'b00, 4'd3);

      @(negedge clk);
      drv(1, I_A24, 32'h24, 8'h19, 0, 1, 1, 5'd1, 0, 0, 5'd0);
      expect_out("async_rst_pre", 1, I_LW, 32'h20, 8'h00, 1, 2'b00, 2'b00, 4'd3);

      @(negedge clk);
      rst = 1'b1;
      expect_out("async_rst_mid", 0, 32'h0, 32'h0, 8'h00, 0, 2'b00, 2'b00, 4'd0);

      @(negedge clk);
      rst = 1'b0;
      expect_out("async_rst_release", 0, 32'h0, 32'h0, 8'h00, 0, 2'b00, 2'b00, 4'd0);

      @(negedge clk);
      drv(1, I_A24, 32'h24, 8'h19, 0, 0, 0, 5'd0, 0, 0, 5'd0);
      expect_out("post_rst_load", 1, I_A24, 32'h24, 8'h19, 0, 2'b00, 2'b00, 4'd0);

      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         drv(1, I_A56, 32'h28, 8'h1A, 0, 1, 1, 5'd2, 0, 0, 5'd0);
         expect_out($sformatf("sat_stall_%0d", k), 1, I_A24, 32'h24, 8'h00, 1,
                    2'b00, 2'b00, (k < 15) ? 4'(k) : 4'd15);
      end

      @(negedge clk);
      drv(1, I_A56, 32'h28, 8'h1A, 0, 0, 0, 5'd0, 0, 0, 5'd0);
      expect_out("sat_hold", 1, I_A24, 32'h24, 8'h19, 0, 2'b00, 2'b00, 4'd15);

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
